// File: rtl/seq_divider_pkg.sv
// ============================================================================
// Module  : seq_divider_pkg
// Brief   : Shared state encoding and default width for the sequential divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_divider_pkg;

    localparam int c_default_n = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/n_bit_subtractor.sv
// ============================================================================
// Module  : n_bit_subtractor
// Brief   : Unsigned a - b as a + ~b + 1; borrow is the inverted carry-out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module n_bit_subtractor
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = c_default_n + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] w_sum;

    assign w_sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign diff   = w_sum[WIDTH-1:0];
    assign borrow = ~w_sum[WIDTH];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module  : seq_divider
// Brief   : Unsigned restoring divider, one quotient bit per clock, N cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = c_default_n
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         dbz
);

    localparam int c_cnt_w = $clog2(N + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [N-1:0]       r_rem;
    logic [N-1:0]       r_dvd;
    logic [N-1:0]       r_dvs;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_accept;
    logic               w_last;
    logic [N:0]         w_shifted;
    logic [N:0]         w_trial;
    logic               w_borrow;
    logic [N-1:0]       w_rem_next;
    logic [N-1:0]       w_quo_next;

    assign w_accept  = start && (r_state != RUN);
    assign w_last    = (r_cnt == c_cnt_w'(1));
    assign w_shifted = {r_rem, r_dvd[N-1]};

    n_bit_subtractor #(
        .WIDTH (N + 1)
    ) u_sub (
        .a      (w_shifted),
        .b      ({1'b0, r_dvs}),
        .diff   (w_trial),
        .borrow (w_borrow)
    );

    // On borrow the shifted remainder is below the divisor, so its top bit is zero.
    assign w_rem_next = w_borrow ? w_shifted[N-1:0] : w_trial[N-1:0];
    // Quotient bits shift into the dividend register as its bits are consumed.
    assign w_quo_next = {r_dvd[N-2:0], ~w_borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = (B == '0) ? DONE : RUN;
                end else if (r_state == DONE) begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_dvd <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
            Q     <= '0;
            R     <= '0;
            dbz   <= 1'b0;
        end else if (w_accept) begin
            r_rem <= '0;
            r_dvd <= A;
            r_dvs <= B;
            r_cnt <= c_cnt_w'(N);
            if (B == '0) begin
                Q   <= '1;
                R   <= A;
                dbz <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_next;
            r_dvd <= w_quo_next;
            r_cnt <= r_cnt - c_cnt_w'(1);
            if (w_last) begin
                Q   <= w_quo_next;
                R   <= w_rem_next;
                dbz <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module  : tb_seq_divider
// Brief   : Directed vector table plus corner sequences for seq_divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;

    localparam int N = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         dbz;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         z;
    } vec_t;

    vec_t vecs [12];

    seq_divider #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called 1ns after a rising edge; returns 1ns after the accepting edge.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int   lat;
        logic bok;
        int   done_cnt;

        vecs[0]  = '{32'd100,        32'd7,         32'd14,        32'd2,      1'b0};
        vecs[1]  = '{32'hFFFFFFFF,   32'd1,         32'hFFFFFFFF,  32'd0,      1'b0};
        vecs[2]  = '{32'd5,          32'd9,         32'd0,         32'd5,      1'b0};
        vecs[3]  = '{32'd1234,       32'd0,         32'hFFFFFFFF,  32'd1234,   1'b1};
        vecs[4]  = '{32'd1000,       32'd10,        32'd100,       32'd0,      1'b0};
        vecs[5]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,  32'd1,         32'd0,      1'b0};
        vecs[6]  = '{32'hFFFFFFFF,   32'd2,         32'h7FFFFFFF,  32'd1,      1'b0};
        vecs[7]  = '{32'd0,          32'd5,         32'd0,         32'd0,      1'b0};
        vecs[8]  = '{32'd12345678,   32'd1000,      32'd12345,     32'd678,    1'b0};
        vecs[9]  = '{32'h80000000,   32'd3,         32'h2AAAAAAA,  32'd2,      1'b0};
        vecs[10] = '{32'd7,          32'd7,         32'd1,         32'd0,      1'b0};
        vecs[11] = '{32'd0,          32'd0,         32'hFFFFFFFF,  32'd0,      1'b1};

        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_q",    64'(Q),    64'd0);
        check("reset_r",    64'(R),    64'd0);
        check("reset_dbz",  64'(dbz),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done(lat, bok);
            check($sformatf("v%0d_latency", i), 64'(lat), (vecs[i].b == 0) ? 64'd0 : 64'd32);
            check($sformatf("v%0d_busy_run", i), 64'(bok), 64'd1);
            check($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
            check($sformatf("v%0d_q", i), 64'(Q), 64'(vecs[i].q));
            check($sformatf("v%0d_r", i), 64'(R), 64'(vecs[i].r));
            check($sformatf("v%0d_dbz", i), 64'(dbz), 64'(vecs[i].z));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
            check($sformatf("v%0d_q_hold", i), 64'(Q), 64'(vecs[i].q));
        end

        // Start during RUN must be dropped without resampling operands.
        launch(32'd234234, 32'd321423);
        repeat (5) @(posedge clk);
        #1;
        A     = 32'd50;
        B     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 6;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ign_latency", 64'(lat), 64'd32);
        check("ign_q",       64'(Q),   64'd0);
        check("ign_r",       64'(R),   64'd234234);
        check("ign_dbz",     64'(dbz), 64'd0);
        @(posedge clk);
        #1;
        check("ign_idle_busy", 64'(busy), 64'd0);
        check("ign_idle_done", 64'(done), 64'd0);

        // Asynchronous reset at step 10 aborts the division.
        launch(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_q",    64'(Q),    64'd0);
        check("abort_r",    64'(R),    64'd0);
        check("abort_dbz",  64'(dbz),  64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_cnt++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);

        // Start held through DONE: a second operation is accepted on the DONE edge.
        A     = 32'd432;
        B     = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat, bok);
        check("b2b1_latency", 64'(lat), 64'd32);
        check("b2b1_q",       64'(Q),   64'd86);
        check("b2b1_r",       64'(R),   64'd2);
        A = 32'd1000;
        B = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b2_busy", 64'(busy), 64'd1);
        check("b2b2_done", 64'(done), 64'd0);
        wait_done(lat, bok);
        check("b2b2_latency", 64'(lat), 64'd32);
        check("b2b2_q",       64'(Q),   64'd100);
        check("b2b2_r",       64'(R),   64'd0);

        // Back-to-back into a divide-by-zero from DONE.
        A     = 32'd77;
        B     = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_dbz_done", 64'(done), 64'd1);
        check("b2b_dbz_flag", 64'(dbz),  64'd1);
        check("b2b_dbz_r",    64'(R),    64'd77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
